stream_fifo: RTL



---
 rtl/stream_fifo_pkg.sv | 17 +
 rtl/fifo_wrap_ptr.sv | 49 ++++
 rtl/stream_fifo.sv | 128 ++++++++++++
 3 files changed

// File: rtl/stream_fifo_pkg.sv
// -----------------------------------------------------------------------------
// stream_fifo_pkg
// Shared width helpers for stream_fifo and its pointer sub-module.
//   ptr_w(depth) : bits needed for a pointer that ranges over 0..depth-1
//   cnt_w(depth) : bits needed for an occupancy count that ranges over 0..depth
// -----------------------------------------------------------------------------
package stream_fifo_pkg;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// -----------------------------------------------------------------------------
// fifo_wrap_ptr
// Modulo-DEPTH pointer register. It advances by one when adv is high. At
// DEPTH-1 it wraps to 0, so it never holds a value of DEPTH or more, even
// when DEPTH is not a power of two.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears the pointer to 0
//   adv  : advance enable
//   ptr  : current pointer value
// -----------------------------------------------------------------------------
module fifo_wrap_ptr
   import stream_fifo_pkg::*;
#(
   parameter int DEPTH = 123
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      adv,
   output logic [ptr_w(DEPTH)-1:0]   ptr
);

   localparam int PW = ptr_w(DEPTH);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (adv) begin
         if (int'(ptr_q) == DEPTH - 1) begin
            ptr_d = '0;
         end else begin
            ptr_d = ptr_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
// Synchronous valid/ready FIFO of arbitrary depth (DEPTH need not be a power
// of two). The read is combinational from the registered read pointer, so a
// word pushed at edge N can be popped in the cycle after N. There is no
// in-to-out bypass, and in_ready does not depend on out_ready.
//
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   in_valid/in_ready   : producer handshake, in_data is the write word
//   out_valid/out_ready : consumer handshake, out_data is the oldest word
//                         (all-zero while empty)
//   count               : number of stored words, 0..DEPTH
//
// Optional build macro STREAM_FIFO_LEVEL_FLAGS_EN adds two registered flags:
//   almost_full  = (count >= AF_LEVEL), cleared to 0 by reset
//   almost_empty = (count <= AE_LEVEL), set to 1 by reset
// Without the macro these ports do not exist, and AF_LEVEL and AE_LEVEL only
// take part in the elaboration sanity check below.
// -----------------------------------------------------------------------------
module stream_fifo
   import stream_fifo_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 123,
   parameter int AF_LEVEL = DEPTH - 4,
   parameter int AE_LEVEL = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
`ifdef STREAM_FIFO_LEVEL_FLAGS_EN
   output logic                     almost_full,
   output logic                     almost_empty,
`endif
   output logic [cnt_w(DEPTH)-1:0]  count
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   // A threshold above DEPTH would never fire, and one at or above DEPTH for
   // almost-empty would always fire. Both are treated as configuration errors.
   if (DEPTH < 2 || DEPTH > 4096 || AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_bad_cfg
      $error("stream_fifo: illegal DEPTH or level thresholds");
   end

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          push;
   logic          pop;

   // Full blocks a push even when a pop happens in the same cycle. This keeps
   // out_ready out of the in_ready path.
   assign in_ready  = !rst && (int'(count_q) < DEPTH);
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign count     = count_q;

   fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .adv (push),
      .ptr (wr_ptr)
   );

   fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .adv (pop),
      .ptr (rd_ptr)
   );

   // Storage is intentionally not reset. The pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

`ifdef STREAM_FIFO_LEVEL_FLAGS_EN
   logic af_q;
   logic ae_q;

   // Flags are computed from count_d so that they change on the same edge as count.
   always_ff @(posedge clk) begin
      if (rst) begin
         af_q <= 1'b0;
         ae_q <= 1'b1;
      end else begin
         af_q <= (int'(count_d) >= AF_LEVEL);
         ae_q <= (int'(count_d) <= AE_LEVEL);
      end
   end

   assign almost_full  = af_q;
   assign almost_empty = ae_q;
`endif

endmodule
